// File: rtl/unidade_acesso_memoria.sv
// Load/store unit between the datapath and a word-wide data memory: byte/half/word access, RMW sub-word stores.
// Optional statistics counters are enabled with the ESTATISTICAS_EN macro.
module unidade_acesso_memoria #(
    parameter int LARGURA_ENDERECO = 32
`ifdef ESTATISTICAS_EN
    ,
    parameter int LARGURA_CONTADOR = 16
`endif
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Req,
    output logic                        Pronto,
    input  logic                        EhEscrita,
    input  logic [1:0]                  Tamanho,
    input  logic                        SemSinal,
    input  logic [LARGURA_ENDERECO-1:0] Endereco,
    input  logic [31:0]                 DadosEscrita,
    output logic                        Concluido,
    output logic [31:0]                 DadosLidos,
    output logic                        ErroAlinhamento,
    output logic [LARGURA_ENDERECO-1:0] MemEndereco,
    output logic [31:0]                 MemDadosEscrita,
    output logic                        MemWrite,
    output logic                        MemRead,
    input  logic [31:0]                 MemDadosLidos
`ifdef ESTATISTICAS_EN
    ,
    output logic [LARGURA_CONTADOR-1:0] TotalLeituras,
    output logic [LARGURA_CONTADOR-1:0] TotalEscritas,
    output logic [LARGURA_CONTADOR-1:0] TotalErros
`endif
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        LEITURA  = 2'b01,
        ESCRITA  = 2'b10,
        RESPOSTA = 2'b11
    } estado_t;

    estado_t                     estado_q, estado_d;
    logic [LARGURA_ENDERECO-1:0] end_q, end_d;
    logic [1:0]                  tam_q, tam_d;
    logic                        sem_sinal_q, sem_sinal_d;
    logic                        eh_escrita_q, eh_escrita_d;
    logic                        erro_q, erro_d;
    logic [31:0]                 palavra_q, palavra_d;
    logic [31:0]                 dados_lidos_q, dados_lidos_d;

    function automatic logic desalinhado(input logic [1:0] tam, input logic [1:0] a);
        logic r;
        case (tam)
            2'b00:   r = 1'b0;
            2'b01:   r = a[0];
            2'b10:   r = (a != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extrai_carga(input logic [31:0] palavra, input logic [1:0] tam,
                                                 input logic [1:0] a, input logic sem_sinal);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = palavra[7:0];
            2'b01:   b = palavra[15:8];
            2'b10:   b = palavra[23:16];
            default: b = palavra[31:24];
        endcase
        h = a[1] ? palavra[31:16] : palavra[15:0];
        case (tam)
            2'b00:   r = sem_sinal ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = sem_sinal ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = palavra;
        endcase
        return r;
    endfunction

    // Inserts the low byte/half of the store data into the lane selected by the address.
    function automatic logic [31:0] funde(input logic [31:0] palavra, input logic [31:0] dado,
                                          input logic [1:0] tam, input logic [1:0] a);
        logic [31:0] r;
        r = palavra;
        case (tam)
            2'b00: begin
                case (a)
                    2'b00:   r[7:0]   = dado[7:0];
                    2'b01:   r[15:8]  = dado[7:0];
                    2'b10:   r[23:16] = dado[7:0];
                    default: r[31:24] = dado[7:0];
                endcase
            end
            2'b01: begin
                if (a[1]) begin
                    r[31:16] = dado[15:0];
                end else begin
                    r[15:0] = dado[15:0];
                end
            end
            default: r = dado;
        endcase
        return r;
    endfunction

    // State and latched request registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q      <= OCIOSO;
            end_q         <= '0;
            tam_q         <= 2'b00;
            sem_sinal_q   <= 1'b0;
            eh_escrita_q  <= 1'b0;
            erro_q        <= 1'b0;
            palavra_q     <= 32'h0000_0000;
            dados_lidos_q <= 32'h0000_0000;
        end else begin
            estado_q      <= estado_d;
            end_q         <= end_d;
            tam_q         <= tam_d;
            sem_sinal_q   <= sem_sinal_d;
            eh_escrita_q  <= eh_escrita_d;
            erro_q        <= erro_d;
            palavra_q     <= palavra_d;
            dados_lidos_q <= dados_lidos_d;
        end
    end

    // Next-state logic; palavra holds the store data, then the merged word for sub-word stores.
    always_comb begin
        estado_d      = estado_q;
        end_d         = end_q;
        tam_d         = tam_q;
        sem_sinal_d   = sem_sinal_q;
        eh_escrita_d  = eh_escrita_q;
        erro_d        = erro_q;
        palavra_d     = palavra_q;
        dados_lidos_d = dados_lidos_q;
        case (estado_q)
            OCIOSO: begin
                if (Req) begin
                    end_d        = Endereco;
                    tam_d        = Tamanho;
                    sem_sinal_d  = SemSinal;
                    eh_escrita_d = EhEscrita;
                    palavra_d    = DadosEscrita;
                    erro_d       = desalinhado(Tamanho, Endereco[1:0]);
                    if (desalinhado(Tamanho, Endereco[1:0])) begin
                        estado_d = RESPOSTA;
                    end else if (!EhEscrita || (Tamanho != 2'b10)) begin
                        estado_d = LEITURA;
                    end else begin
                        estado_d = ESCRITA;
                    end
                end else begin
                    estado_d = OCIOSO;
                end
            end
            LEITURA: begin
                if (eh_escrita_q) begin
                    palavra_d = funde(MemDadosLidos, palavra_q, tam_q, end_q[1:0]);
                    estado_d  = ESCRITA;
                end else begin
                    dados_lidos_d = extrai_carga(MemDadosLidos, tam_q, end_q[1:0], sem_sinal_q);
                    estado_d      = RESPOSTA;
                end
            end
            ESCRITA:  estado_d = RESPOSTA;
            RESPOSTA: estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    // Moore outputs decoded from the state and latched registers only.
    always_comb begin
        Pronto          = (estado_q == OCIOSO);
        MemRead         = (estado_q == LEITURA);
        MemWrite        = (estado_q == ESCRITA);
        Concluido       = (estado_q == RESPOSTA);
        ErroAlinhamento = (estado_q == RESPOSTA) && erro_q;
        MemEndereco     = {end_q[LARGURA_ENDERECO-1:2], 2'b00};
        MemDadosEscrita = palavra_q;
        DadosLidos      = dados_lidos_q;
    end

`ifdef ESTATISTICAS_EN
    localparam logic [LARGURA_CONTADOR-1:0] UM = {{(LARGURA_CONTADOR-1){1'b0}}, 1'b1};

    logic [LARGURA_CONTADOR-1:0] leituras_q, leituras_d;
    logic [LARGURA_CONTADOR-1:0] escritas_q, escritas_d;
    logic [LARGURA_CONTADOR-1:0] erros_q, erros_d;

    // Saturating completion counters, bumped while in RESPOSTA.
    always_comb begin
        leituras_d = leituras_q;
        escritas_d = escritas_q;
        erros_d    = erros_q;
        if (estado_q == RESPOSTA) begin
            if (erro_q) begin
                erros_d = (erros_q == '1) ? erros_q : erros_q + UM;
            end else if (eh_escrita_q) begin
                escritas_d = (escritas_q == '1) ? escritas_q : escritas_q + UM;
            end else begin
                leituras_d = (leituras_q == '1) ? leituras_q : leituras_q + UM;
            end
        end else begin
            erros_d = erros_q;
        end
    end

    // Counter registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            leituras_q <= '0;
            escritas_q <= '0;
            erros_q    <= '0;
        end else begin
            leituras_q <= leituras_d;
            escritas_q <= escritas_d;
            erros_q    <= erros_d;
        end
    end

    assign TotalLeituras = leituras_q;
    assign TotalEscritas = escritas_q;
    assign TotalErros    = erros_q;
`endif

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Self-checking bench for unidade_acesso_memoria: small word memory plus a transaction-level reference model.
module tb_unidade_acesso_memoria;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req;
    logic        Pronto;
    logic        EhEscrita;
    logic [1:0]  Tamanho;
    logic        SemSinal;
    logic [31:0] Endereco;
    logic [31:0] DadosEscrita;
    logic        Concluido;
    logic [31:0] DadosLidos;
    logic        ErroAlinhamento;
    logic [31:0] MemEndereco;
    logic [31:0] MemDadosEscrita;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemDadosLidos;
`ifdef ESTATISTICAS_EN
    logic [15:0] TotalLeituras, TotalEscritas, TotalErros;
`endif

    unidade_acesso_memoria dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Pronto(Pronto), .EhEscrita(EhEscrita),
        .Tamanho(Tamanho), .SemSinal(SemSinal), .Endereco(Endereco), .DadosEscrita(DadosEscrita),
        .Concluido(Concluido), .DadosLidos(DadosLidos), .ErroAlinhamento(ErroAlinhamento),
        .MemEndereco(MemEndereco), .MemDadosEscrita(MemDadosEscrita), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemDadosLidos(MemDadosLidos)
`ifdef ESTATISTICAS_EN
        , .TotalLeituras(TotalLeituras), .TotalEscritas(TotalEscritas), .TotalErros(TotalErros)
`endif
    );

    always #5 Clock = ~Clock;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    bit          mem_init = 1'b0;

    assign MemDadosLidos = mem[MemEndereco[5:2]];

    always @(posedge Clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (MemWrite) begin
            mem[MemEndereco[5:2]] <= MemDadosEscrita;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    // Per-cycle expectations, set by the driver just after each rising edge.
    bit          chk_en = 1'b0;
    logic        e_pronto, e_concl, e_erro, e_rd, e_wr;
    logic [31:0] e_dl, e_addr, e_wdata;

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("Pronto", 32'(Pronto), 32'(e_pronto));
            chk("Concluido", 32'(Concluido), 32'(e_concl));
            chk("ErroAlinhamento", 32'(ErroAlinhamento), 32'(e_erro));
            chk("MemRead", 32'(MemRead), 32'(e_rd));
            chk("MemWrite", 32'(MemWrite), 32'(e_wr));
            chk("DadosLidos", DadosLidos, e_dl);
            if (e_rd || e_wr) chk("MemEndereco", MemEndereco, e_addr);
            if (e_wr) chk("MemDadosEscrita", MemDadosEscrita, e_wdata);
        end
    end

    function automatic bit mis(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [31:0] carga(input logic [31:0] w, input logic [1:0] sz,
                                          input logic sgn, input logic [1:0] a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * a)) & 32'h0000_00FF;
            if (!sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'h0000_FFFF;
            if (!sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] mask;
        int sh;
        mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        sh   = (sz == 2'd0) ? 8 * a : (sz == 2'd1) ? 16 * a[1] : 0;
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    task automatic set_idle();
        e_pronto = 1'b1; e_concl = 1'b0; e_erro = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    endtask

    // Starts at a falling edge with the unit idle; returns at a falling edge with it idle again.
    task automatic access(input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] data, input bit keep);
        int L;
        int idx;
        bit err;
        logic [31:0] novo, res;
        err  = mis(sz, addr[1:0]);
        idx  = int'(addr[5:2]);
        L    = err ? 1 : ((!wr || sz == 2'd2) ? 2 : 3);
        novo = wr ? merge(ref_mem[idx], data, sz, addr[1:0]) : ref_mem[idx];
        res  = carga(ref_mem[idx], sz, sgn, addr[1:0]);
        Req = 1'b1; EhEscrita = wr; Tamanho = sz; SemSinal = sgn; Endereco = addr; DadosEscrita = data;
        @(posedge Clock); #1;
        if (!keep) begin
            Req = 1'b0; EhEscrita = 1'($urandom); Tamanho = 2'($urandom); SemSinal = 1'($urandom);
            Endereco = $urandom; DadosEscrita = $urandom;
        end
        e_addr = {addr[31:2], 2'b00};
        e_wdata = novo;
        for (int k = 1; k <= L; k++) begin
            e_pronto = 1'b0;
            e_concl  = (k == L);
            e_erro   = (k == L) && err;
            e_rd     = !err && (k == 1) && (!wr || sz != 2'd2);
            e_wr     = !err && wr && (k == L - 1);
            if (k == L && !err && !wr) e_dl = res;
            @(posedge Clock); #1;
        end
        set_idle();
        if (wr && !err) ref_mem[idx] = novo;
        @(negedge Clock);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    bit seen_c, seen_w;

    initial begin
        Reset = 1'b0; Req = 1'b0; EhEscrita = 1'b0; Tamanho = 2'b00; SemSinal = 1'b0;
        Endereco = 32'h0; DadosEscrita = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        set_idle();
        e_dl = 32'h0; e_addr = 32'h0; e_wdata = 32'h0;
        repeat (2) @(negedge Clock);
        mem_init = 1'b1;
        chk("rst_Pronto", 32'(Pronto), 32'd1);
        chk("rst_Concluido", 32'(Concluido), 32'd0);
        chk("rst_Erro", 32'(ErroAlinhamento), 32'd0);
        chk("rst_MemRead", 32'(MemRead), 32'd0);
        chk("rst_MemWrite", 32'(MemWrite), 32'd0);
        chk("rst_DadosLidos", DadosLidos, 32'h0);
        chk("rst_MemEndereco", MemEndereco, 32'h0);
        chk("rst_MemDadosEscrita", MemDadosEscrita, 32'h0);
        Reset = 1'b1;
        chk_en = 1'b1;
        @(negedge Clock);

        access(1'b1, 2'd2, 1'b0, 32'd8, 32'd24, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 1'b0);
        chk("lw8", DadosLidos, 32'h0000_0018);
        access(1'b1, 2'd2, 1'b0, 32'd8, 32'h1122_3344, 1'b0);
        access(1'b1, 2'd0, 1'b0, 32'd9, 32'h0000_00AB, 1'b0);
        chk("sb9_word", mem[2], 32'h1122_AB44);
        access(1'b0, 2'd0, 1'b0, 32'd9, 32'd0, 1'b0);
        chk("lb9", DadosLidos, 32'hFFFF_FFAB);
        access(1'b0, 2'd0, 1'b1, 32'd9, 32'd0, 1'b0);
        chk("lbu9", DadosLidos, 32'h0000_00AB);
        access(1'b1, 2'd2, 1'b0, 32'd12, 32'h80FF_1234, 1'b0);
        access(1'b0, 2'd1, 1'b0, 32'd14, 32'd0, 1'b0);
        chk("lh14", DadosLidos, 32'hFFFF_80FF);
        access(1'b0, 2'd1, 1'b1, 32'd14, 32'd0, 1'b0);
        chk("lhu14", DadosLidos, 32'h0000_80FF);
        access(1'b0, 2'd1, 1'b0, 32'd12, 32'd0, 1'b0);
        chk("lh12", DadosLidos, 32'h0000_1234);
        access(1'b1, 2'd2, 1'b0, 32'd6, 32'hDEAD_BEEF, 1'b0);
        chk("mis_DadosLidos", DadosLidos, 32'h0000_1234);

        // Reset pulsed while a byte store is in its read phase.
        chk_en = 1'b0;
        Req = 1'b1; EhEscrita = 1'b1; Tamanho = 2'd0; SemSinal = 1'b0; Endereco = 32'd8; DadosEscrita = 32'h55;
        @(posedge Clock); #1;
        Req = 1'b0;
        chk("rst_mid_MemRead_before", 32'(MemRead), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("rst_mid_MemRead", 32'(MemRead), 32'd0);
        chk("rst_mid_Pronto", 32'(Pronto), 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        seen_c = 1'b0; seen_w = 1'b0;
        repeat (5) begin
            @(negedge Clock);
            if (Concluido) seen_c = 1'b1;
            if (MemWrite) seen_w = 1'b1;
        end
        chk("rst_mid_no_Concluido", 32'(seen_c), 32'd0);
        chk("rst_mid_no_MemWrite", 32'(seen_w), 32'd0);
        chk("rst_mid_word8", mem[2], 32'h1122_AB44);
        chk("rst_mid_Pronto_after", 32'(Pronto), 32'd1);
        e_dl = 32'h0;
        set_idle();
        chk_en = 1'b1;
        @(negedge Clock);

        // Req held through a whole load, then a second access accepted right after.
        access(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 1'b1);
        access(1'b0, 2'd2, 1'b1, 32'd12, 32'd0, 1'b0);
        chk("held_lw12", DadosLidos, 32'h80FF_1234);

        for (int n = 0; n < 300; n++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            access(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 63)), $urandom,
                   bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                Req = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge Clock);
            end
        end
        Req = 1'b0;
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
